// File: rtl/alu_serial_if.sv
// Operand/result handshake bundle for alu_serial.
// ovf exists only when ALU_SERIAL_OVF_EN is defined.
interface alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       s;
    logic             m;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, s, m, out_ready,
`ifdef ALU_SERIAL_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, f, cout, zero
    );

    modport slave (
        input  in_valid, a, b, cin, s, m, out_ready,
`ifdef ALU_SERIAL_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, f, cout, zero
    );
endinterface

// File: rtl/alu_serial.sv
// Digit-serial ALU: WIDTH-bit AND/OR/XOR/XNOR and add variants, DIGIT bits per clock.
// Optional signed-overflow output enabled by ALU_SERIAL_OVF_EN.
module alu_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic        clk,
    input logic        rst_n,
    alu_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
    logic             carry_q, carry_d, cout_q, cout_d, m_q, m_d;
    logic [1:0]       s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] dig_res;
    logic             c_w, bo_w;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf_q, ovf_d, dig_cmsb;
`endif

    // One digit of the slice function; operands shift right so bit 0 is always current.
    always_comb begin
        c_w     = carry_q;
        bo_w    = 1'b0;
        dig_res = '0;
`ifdef ALU_SERIAL_OVF_EN
        dig_cmsb = 1'b0;
`endif
        for (int i = 0; i < DIGIT; i++) begin
            case (s_q)
                2'b00:   bo_w = b_q[i];
                2'b01:   bo_w = ~b_q[i];
                2'b10:   bo_w = 1'b0;
                default: bo_w = 1'b1;
            endcase
`ifdef ALU_SERIAL_OVF_EN
            dig_cmsb = c_w;
`endif
            if (m_q) begin
                dig_res[i] = a_q[i] ^ bo_w ^ c_w;
                c_w        = (a_q[i] & bo_w) | (c_w & (a_q[i] ^ bo_w));
            end else begin
                case (s_q)
                    2'b00:   dig_res[i] = a_q[i] & b_q[i];
                    2'b01:   dig_res[i] = a_q[i] | b_q[i];
                    2'b10:   dig_res[i] = a_q[i] ^ b_q[i];
                    default: dig_res[i] = ~(a_q[i] ^ b_q[i]);
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        s_d     = s_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.a;
                b_d     = bus.b;
                carry_d = bus.cin;
                s_d     = bus.s;
                m_d     = bus.m;
                f_d     = '0;
                cout_d  = 1'b0;
                cnt_d   = '0;
`ifdef ALU_SERIAL_OVF_EN
                ovf_d   = 1'b0;
`endif
                state_d = RUN;
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = c_w;
                // New digit enters at the top so after NDIG shifts it lands in place.
                f_d     = (f_q >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    cout_d  = m_q & c_w;
`ifdef ALU_SERIAL_OVF_EN
                    ovf_d   = m_q & (c_w ^ dig_cmsb);
`endif
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            s_q     <= 2'b00;
            m_q     <= 1'b0;
            cnt_q   <= '0;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            s_q     <= s_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.f         = f_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = ~|f_q;
`ifdef ALU_SERIAL_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised successor to the `Mock1` single-bit ALU slice: a `WIDTH`-bit ALU that evaluates `DIGIT` bits per clock using the same 3-bit function select (`S1`, `S0`, `M`) plus a carry input. Operands enter through a valid/ready handshake. Results leave through a valid/ready handshake and stay stable under backpressure. It is the multi-bit, sequential datapath element built from the slice function, trading latency for area.

## Interface
- `WIDTH`, 8, operand/result width in bits; must be a multiple of `DIGIT`
- `DIGIT`, 1, bits processed per cycle; `DIGIT == WIDTH` gives single-cycle evaluation
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  operand set presented
- `in_ready`  out  1  block can accept an operand set
- `a`, `b`  in  `WIDTH`  operands
- `cin`  in  1  carry input
- `s`  in  2  function select {S1,S0}
- `m`  in  1  mode: 0 = logic, 1 = arithmetic
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `f`  out  `WIDTH`  result
- `cout`  out  1  carry out of the MSB
- `zero`  out  1  `f == 0`

## Operation
- **Logic mode (m=0)**, per bit:
  - s=00: AND
  - s=01: OR
  - s=10: XOR
  - s=11: XNOR
  - `cin` is ignored and `cout` is 0.
- **Arithmetic mode (m=1)**, modulo 2^WIDTH:
  - s=00: A+B+cin
  - s=01: A+~B+cin (subtract when cin=1)
  - s=10: A+cin
  - s=11: A+all-ones+cin (decrement when cin=0)
  - `cout` is the carry out of bit WIDTH-1.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. When `in_valid` is high, capture a, b, cin, s, m, clear the result shift register and go to RUN.
  - RUN: each cycle, compute `DIGIT` result bits LSB-first, starting at digit 0. The carry propagates internally between digits. After digit WIDTH/DIGIT-1 is computed, go to DONE.
  - DONE: `out_valid`=1. When `out_ready` is high, go to IDLE.
- Operands are captured at accept. Changes on `a`/`b`/`s`/`m`/`cin` outside the accept cycle have no effect.
- `in_valid` is ignored in RUN and DONE because `in_ready` is 0 there.
- `f`, `cout` and `zero` are meaningful only while `out_valid` is high. They hold their final values until the next accept.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `f`=0, `cout`=0, `zero`=1 (and `ovf`=0 when configured).
- Latency: an accept at edge N raises `out_valid` after edge N+WIDTH/DIGIT.
- Throughput: one operation per WIDTH/DIGIT+2 cycles when `out_ready` is held high (accept, RUN cycles, DONE handshake, return to IDLE).
- `in_ready` is purely a decode of the IDLE state. There is no combinational path from `out_ready` to `in_ready`.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `f`, `cout` and `zero` are frozen.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned immediately and all outputs go to their reset values. Nothing is replayed after release.
- `DIGIT == WIDTH`: RUN lasts exactly one cycle.

## Configuration
- `ALU_SERIAL_OVF_EN`: when defined, the block adds output `ovf` (1 bit).
  - `ovf` is the signed overflow of the arithmetic op: carry-in to the MSB XOR carry-out of the MSB.
  - `ovf` is 0 in logic mode.
  - It follows the same valid/hold/reset rules as `cout`.
- When the macro is undefined, the port and its logic are absent.

## Test plan
- **Add with wrap:** WIDTH=8, DIGIT=1, a=8'hFF, b=8'h01, cin=0, m=1, s=00 -> `out_valid` rises 8 cycles after accept with f=8'h00, cout=1, zero=1.
- **Subtract:** a=8'h10, b=8'h01, cin=1, m=1, s=01 -> f=8'h0F, cout=1, zero=0.
- **Logic:** a=8'hA5, b=8'hFF, m=0, s=10, cin=1 -> f=8'h5A, cout=0. Then s=11 -> f=8'hA5.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid`.
  - f, cout and zero stay constant and `in_ready` stays 0.
  - Raising `out_ready` gives `in_ready`=1 on the next cycle.
- **Reset mid-RUN:** pulse `rst_n` low at RUN cycle 3.
  - `out_valid`=0, f=0 and `in_ready`=1 immediately.
  - A following op (8'h03+8'h04) gives f=8'h07.
- **Wide digit:** WIDTH=8, DIGIT=4, a=8'h7F, b=8'h01, cin=0, m=1, s=00 -> f=8'h80 after 2 RUN cycles, cout=0, and `ovf`=1 with `ALU_SERIAL_OVF_EN` defined.
